// File: rtl/mcu_spi_target.sv
// SPI mode-0 target for the MCU link: oversamples CSn/SCK/MOSI in the clk domain,
// delivers received bytes as strobes and shifts reply bytes out on MISO one byte late.
module mcu_spi_target (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_csn,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       data_in_strobe,
    output logic       data_in_start,
    output logic [7:0] data_in,
    input  logic [7:0] data_out,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t     state;
    logic [2:0] csn_sync;
    logic [2:0] sck_sync;
    logic [1:0] mosi_sync;
    logic [1:0] sync_fill;
    logic       armed;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic       first_byte;

    logic csn_fall;
    logic csn_rise;
    logic sck_rise;
    logic sck_fall;
    logic load_tx;

    assign csn_fall = csn_sync[2] & ~csn_sync[1];
    assign csn_rise = ~csn_sync[2] & csn_sync[1];
    assign sck_rise = ~sck_sync[2] & sck_sync[1];
    assign sck_fall = sck_sync[2] & ~sck_sync[1];
    assign busy     = ~csn_sync[1];
    // A falling edge only counts at a byte boundary reached by wrapping, never at frame start.
    assign load_tx  = (bit_cnt == 3'd0) && !first_byte;

    // The reset value of the CSn synchronizer is not a real observation of the pin, so a
    // frame may only open after CSn has been genuinely seen high (armed) since reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            csn_sync       <= 3'b111;
            sck_sync       <= 3'b000;
            mosi_sync      <= 2'b00;
            sync_fill      <= 2'b00;
            armed          <= 1'b0;
            bit_cnt        <= 3'd0;
            rx_shift       <= 8'h00;
            tx_shift       <= 8'h00;
            first_byte     <= 1'b1;
            data_in_strobe <= 1'b0;
            data_in_start  <= 1'b0;
            data_in        <= 8'h00;
            spi_miso       <= 1'b0;
        end else begin
            csn_sync       <= {csn_sync[1:0], spi_csn};
            sck_sync       <= {sck_sync[1:0], spi_sck};
            mosi_sync      <= {mosi_sync[0], spi_mosi};
            sync_fill      <= {sync_fill[0], 1'b1};
            data_in_strobe <= 1'b0;
            data_in_start  <= 1'b0;
            if (sync_fill[1] && csn_sync[1]) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    spi_miso <= 1'b0;
                    if (csn_fall && armed) begin
                        state      <= ACTIVE;
                        bit_cnt    <= 3'd0;
                        first_byte <= 1'b1;
                        tx_shift   <= 8'h00;
                    end
                end
                ACTIVE: begin
                    if (csn_rise) begin
                        state    <= IDLE;
                        bit_cnt  <= 3'd0;
                        spi_miso <= 1'b0;
                    end else if (sck_rise) begin
                        rx_shift <= {rx_shift[6:0], mosi_sync[1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            data_in_strobe <= 1'b1;
                            data_in_start  <= first_byte;
                            data_in        <= {rx_shift[6:0], mosi_sync[1]};
                            first_byte     <= 1'b0;
                        end
                    end else if (sck_fall) begin
                        if (load_tx) begin
                            tx_shift <= data_out;
                            spi_miso <= data_out[7];
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            spi_miso <= tx_shift[6];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_spi_target.sv
// Directed bench for mcu_spi_target: bit-banged SPI master with timed phases and a strobe
// monitor; expected bytes and MISO replies are hand-computed constants.
module tb_mcu_spi_target;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_mosi = 1'b0;
    logic [7:0] data_out = 8'h00;
    logic       spi_miso;
    logic       data_in_strobe;
    logic       data_in_start;
    logic [7:0] data_in;
    logic       busy;

    int         checks_total = 0;
    int         checks_passed = 0;
    int         checks_failed = 0;
    logic [8:0] stb_q[$];
    logic       busy_gap = 1'b0;
    logic [7:0] m0, m1, m2, m3;

    mcu_spi_target dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .spi_csn       (spi_csn),
        .spi_sck       (spi_sck),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .data_in_strobe(data_in_strobe),
        .data_in_start (data_in_start),
        .data_in       (data_in),
        .data_out      (data_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_in_strobe) begin
            stb_q.push_back({data_in_start, data_in});
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Clocks out nbits of b MSB first; reply is presented on data_out at the byte's last falling edge.
    task automatic applyStimulus(input logic [7:0] b, input int nbits, input logic [7:0] reply,
                                 output logic [7:0] miso_byte);
        miso_byte = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = b[i];
            waitClocks(HALF);
            miso_byte[i] = spi_miso;
            if (!busy) busy_gap = 1'b1;
            spi_sck = 1'b1;
            waitClocks(HALF);
            if (i == 0) data_out = reply;
            spi_sck = 1'b0;
        end
    endtask

    task automatic frameStart();
        spi_csn = 1'b0;
        waitClocks(HALF);
    endtask

    task automatic frameEnd();
        waitClocks(HALF);
        spi_csn = 1'b1;
        waitClocks(8);
    endtask

    initial begin
        int starts;
        int bad_data;
        logic [7:0] b;

        waitClocks(4);
        checkOutput("rst_strobe", data_in_strobe, 0);
        checkOutput("rst_start", data_in_start, 0);
        checkOutput("rst_data_in", data_in, 0);
        checkOutput("rst_miso", spi_miso, 0);
        checkOutput("rst_busy", busy, 0);
        reset_n = 1'b1;
        waitClocks(6);

        $display("[TB] four zero bytes with replies 5C,42,01");
        stb_q.delete();
        frameStart();
        checkOutput("pre_edge_miso", spi_miso, 0);
        applyStimulus(8'h00, 8, 8'h5C, m0);
        applyStimulus(8'h00, 8, 8'h42, m1);
        applyStimulus(8'h00, 8, 8'h01, m2);
        applyStimulus(8'h00, 8, 8'h00, m3);
        frameEnd();
        checkOutput("f1_count", stb_q.size(), 4);
        if (stb_q.size() == 4) begin
            checkOutput("f1_b0", stb_q[0], 9'h100);
            checkOutput("f1_b1", stb_q[1], 9'h000);
            checkOutput("f1_b2", stb_q[2], 9'h000);
            checkOutput("f1_b3", stb_q[3], 9'h000);
        end
        checkOutput("f1_miso0", m0, 8'h00);
        checkOutput("f1_miso1", m1, 8'h5C);
        checkOutput("f1_miso2", m2, 8'h42);
        checkOutput("f1_miso3", m3, 8'h01);
        checkOutput("idle_miso", spi_miso, 0);
        checkOutput("idle_busy", busy, 0);

        $display("[TB] frame 04,43,02");
        stb_q.delete();
        busy_gap = 1'b0;
        frameStart();
        applyStimulus(8'h04, 8, 8'h00, m0);
        applyStimulus(8'h43, 8, 8'h00, m0);
        applyStimulus(8'h02, 8, 8'h00, m0);
        checkOutput("f2_busy_end", busy, 1);
        frameEnd();
        checkOutput("f2_busy_gap", busy_gap, 0);
        checkOutput("f2_count", stb_q.size(), 3);
        if (stb_q.size() == 3) begin
            checkOutput("f2_b0", stb_q[0], 9'h104);
            checkOutput("f2_b1", stb_q[1], 9'h043);
            checkOutput("f2_b2", stb_q[2], 9'h002);
        end

        $display("[TB] partial byte then frame 01,03");
        stb_q.delete();
        frameStart();
        applyStimulus(8'hA5, 5, 8'h00, m0);
        frameEnd();
        checkOutput("partial_count", stb_q.size(), 0);
        frameStart();
        applyStimulus(8'h01, 8, 8'h00, m0);
        applyStimulus(8'h03, 8, 8'h00, m0);
        frameEnd();
        checkOutput("f3_count", stb_q.size(), 2);
        if (stb_q.size() == 2) begin
            checkOutput("f3_b0", stb_q[0], 9'h101);
            checkOutput("f3_b1", stb_q[1], 9'h003);
        end

        $display("[TB] reset mid-frame with CSn held low");
        stb_q.delete();
        frameStart();
        applyStimulus(8'h7E, 4, 8'h00, m0);
        reset_n = 1'b0;
        waitClocks(3);
        checkOutput("mid_rst_strobe", data_in_strobe, 0);
        checkOutput("mid_rst_start", data_in_start, 0);
        checkOutput("mid_rst_data_in", data_in, 0);
        checkOutput("mid_rst_miso", spi_miso, 0);
        checkOutput("mid_rst_busy", busy, 0);
        reset_n = 1'b1;
        waitClocks(HALF);
        data_out = 8'hFF;
        applyStimulus(8'hFF, 8, 8'hFF, m0);
        applyStimulus(8'hFF, 8, 8'hFF, m1);
        checkOutput("post_rst_count", stb_q.size(), 0);
        checkOutput("post_rst_miso", m1, 8'h00);
        spi_csn = 1'b1;
        waitClocks(8);
        frameStart();
        applyStimulus(8'h7E, 8, 8'h00, m0);
        frameEnd();
        checkOutput("f4_count", stb_q.size(), 1);
        if (stb_q.size() == 1) begin
            checkOutput("f4_b0", stb_q[0], 9'h17E);
        end

        $display("[TB] SCK toggling with CSn high");
        stb_q.delete();
        data_out = 8'hFF;
        applyStimulus(8'hA5, 8, 8'hFF, m0);
        applyStimulus(8'h5A, 8, 8'hFF, m1);
        waitClocks(HALF);
        checkOutput("idle_sck_count", stb_q.size(), 0);
        checkOutput("idle_sck_miso", {m0, m1}, 16'h0000);

        $display("[TB] 300-byte frame");
        stb_q.delete();
        frameStart();
        for (int i = 0; i < 300; i++) begin
            b = i[7:0];
            applyStimulus(b, 8, 8'h00, m0);
        end
        frameEnd();
        checkOutput("long_count", stb_q.size(), 300);
        starts = 0;
        bad_data = 0;
        foreach (stb_q[i]) begin
            if (stb_q[i][8]) starts++;
            if (stb_q[i][7:0] !== i[7:0]) bad_data++;
        end
        checkOutput("long_starts", starts, 1);
        if (stb_q.size() > 0) begin
            checkOutput("long_first_start", stb_q[0][8], 1);
        end
        checkOutput("long_data_errors", bad_data, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
